// File: rtl/ldpc_sched_pkg.sv
// Shared definitions for the NB-LDPC row scheduler: default widths and FSM states.
package ldpc_sched_pkg;

  localparam int ADDR_W_DEF   = 10;
  localparam int ITER_W_DEF   = 5;
  localparam int PIPE_LAT_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVEN  = 3'd1,
    S_ODD   = 3'd2,
    S_DRAIN = 3'd3,
    S_SYND  = 3'd4,
    S_FIN   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/ldpc_stride_addr_gen.sv
// Stride-2 row address counter, reloaded with offset 0 or 1 at the start of each pass.
module ldpc_stride_addr_gen
  import ldpc_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              offset,
  input  logic              advance,
  input  logic [ADDR_W-1:0] n_rows,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W:0] addr_plus2;

  // One extra bit keeps the end-of-pass test correct for n_rows near 2^ADDR_W.
  assign addr_plus2 = {1'b0, addr} + (ADDR_W + 1)'(2);
  assign last       = (addr_plus2 >= {1'b0, n_rows});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= {{(ADDR_W - 1){1'b0}}, offset};
    end else if (advance) begin
      addr <= addr + ADDR_W'(2);
    end
  end

endmodule

// File: rtl/ldpc_row_scheduler.sv
// Row scheduler for one NB-LDPC GF16 decode: even pass, odd pass, drain, syndrome
// check, repeated until the syndrome passes or the iteration limit is reached.
module ldpc_row_scheduler
  import ldpc_sched_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ITER_W   = ITER_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_rows,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              dp_ready,
  input  logic              synd_valid,
  input  logic              synd_ok,
  output logic [ADDR_W-1:0] row_addr,
  output logic              row_valid,
  output logic              phase,
  output logic              synd_req,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              success
);

  localparam int                 DRAIN_W    = $clog2(PIPE_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  sched_state_t        state, state_d;
  logic [ADDR_W-1:0]   n_rows_q;
  logic [ITER_W-1:0]   max_iter_q;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic gen_load, gen_off, gen_adv, gen_last;
  logic latch, iter_clr, iter_inc, drain_clr;
  logic synd_req_d, done_d, succ_set, succ_clr;
  logic accept;

  assign accept = row_valid & dp_ready;

  ldpc_stride_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (gen_load),
    .offset  (gen_off),
    .advance (gen_adv),
    .n_rows  (n_rows_q),
    .addr    (row_addr),
    .last    (gen_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    gen_load   = 1'b0;
    gen_off    = 1'b0;
    gen_adv    = 1'b0;
    latch      = 1'b0;
    iter_clr   = 1'b0;
    iter_inc   = 1'b0;
    drain_clr  = 1'b0;
    synd_req_d = 1'b0;
    done_d     = 1'b0;
    succ_set   = 1'b0;
    succ_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch    = 1'b1;
          iter_clr = 1'b1;
          succ_clr = 1'b1;
          if (n_rows == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = S_EVEN;
            gen_load = 1'b1;
          end
        end
      end
      S_EVEN: begin
        if (accept) begin
          if (!gen_last) begin
            gen_adv = 1'b1;
          end else if (n_rows_q == ADDR_W'(1)) begin
            // A single row has no odd partner: skip the odd pass entirely.
            state_d   = S_DRAIN;
            drain_clr = 1'b1;
          end else begin
            state_d  = S_ODD;
            gen_load = 1'b1;
            gen_off  = 1'b1;
          end
        end
      end
      S_ODD: begin
        if (accept) begin
          if (!gen_last) begin
            gen_adv = 1'b1;
          end else begin
            state_d   = S_DRAIN;
            drain_clr = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_d    = S_SYND;
          synd_req_d = 1'b1;
        end
      end
      S_SYND: begin
        if (synd_valid) begin
          iter_inc = 1'b1;
          if (synd_ok) begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            succ_set = 1'b1;
          end else if (iter_cnt + ITER_W'(1) == max_iter_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = S_EVEN;
            gen_load = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decode parameters captured at start; mid-decode input changes never reach them.
  always_ff @(posedge clk) begin
    if (latch) begin
      n_rows_q   <= n_rows;
      max_iter_q <= (max_iter == '0) ? ITER_W'(1) : max_iter;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_cnt  <= '0;
      drain_cnt <= '0;
      success   <= 1'b0;
      row_valid <= 1'b0;
      phase     <= 1'b0;
      busy      <= 1'b0;
      synd_req  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (iter_clr) begin
        iter_cnt <= '0;
      end else if (iter_inc) begin
        iter_cnt <= iter_cnt + ITER_W'(1);
      end
      if (drain_clr) begin
        drain_cnt <= '0;
      end else if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      end
      if (succ_clr) begin
        success <= 1'b0;
      end else if (succ_set) begin
        success <= 1'b1;
      end
      // Outputs follow the next state so they line up with the state register.
      row_valid <= (state_d == S_EVEN) || (state_d == S_ODD);
      phase     <= (state_d == S_ODD);
      busy      <= (state_d == S_EVEN) || (state_d == S_ODD) ||
                   (state_d == S_DRAIN) || (state_d == S_SYND);
      synd_req  <= synd_req_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_ldpc_row_scheduler.sv
// Scoreboard bench for ldpc_row_scheduler: driver pushes expected rows/results,
// an independent monitor pops and compares on every accepted row and done pulse.
module tb_ldpc_row_scheduler;

  localparam int ADDR_W   = 10;
  localparam int ITER_W   = 5;
  localparam int PIPE_LAT = 3;

  typedef struct {
    int addr;
    bit ph;
  } row_t;

  typedef struct {
    bit s;
    int it;
    int lat;
  } res_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] n_rows_in;
  logic [ITER_W-1:0] max_iter_in;
  logic              dp_ready;
  logic              synd_valid;
  logic              synd_ok;
  logic [ADDR_W-1:0] row_addr;
  logic              row_valid;
  logic              phase;
  logic              synd_req;
  logic [ITER_W-1:0] iter_cnt;
  logic              busy;
  logic              done;
  logic              success;

  row_t      row_q[$];
  res_t      res_q[$];
  bit [31:0] plan;
  int        errors = 0;
  int        checks = 0;
  int        tmo_events = 0;

  ldpc_row_scheduler #(
    .ADDR_W   (ADDR_W),
    .ITER_W   (ITER_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .n_rows     (n_rows_in),
    .max_iter   (max_iter_in),
    .dp_ready   (dp_ready),
    .synd_valid (synd_valid),
    .synd_ok    (synd_ok),
    .row_addr   (row_addr),
    .row_valid  (row_valid),
    .phase      (phase),
    .synd_req   (synd_req),
    .iter_cnt   (iter_cnt),
    .busy       (busy),
    .done       (done),
    .success    (success)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: every iteration visits all even rows then all odd rows; stop on
  // the first passing syndrome or once the effective iteration limit is used up.
  function automatic void model_push(int n, int mi);
    int eff;
    int it;
    bit s;
    eff = (mi == 0) ? 1 : mi;
    it  = 0;
    s   = 1'b0;
    if (n > 0) begin
      while (1) begin
        for (int a = 0; a < n; a += 2) row_q.push_back('{a, 1'b0});
        for (int a = 1; a < n; a += 2) row_q.push_back('{a, 1'b1});
        it++;
        if (plan[it-1]) begin
          s = 1'b1;
          break;
        end
        if (it == eff) break;
      end
    end
    res_q.push_back('{s, it, (n == 0) ? 2 : 0});
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin : monitor
    int   cyc;
    int   start_cyc;
    int   idle_run;
    int   tmo_acked;
    bit   prev_stall;
    int   prev_addr;
    row_t r;
    res_t e;
    cyc = 0; start_cyc = 0; idle_run = 0; tmo_acked = 0; prev_stall = 0; prev_addr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tmo_events != tmo_acked) begin
        chk(1'b0, "done_timeout", tmo_events, tmo_acked);
        tmo_acked = tmo_events;
      end
      if (!rst_n) begin
        chk({row_addr, row_valid, phase, synd_req, iter_cnt, busy, done, success} == '0,
            "reset_outputs",
            longint'({row_addr, row_valid, phase, synd_req, iter_cnt, busy, done, success}), 0);
        row_q.delete();
        res_q.delete();
        idle_run   = 0;
        prev_stall = 1'b0;
      end else begin
        if (start && !busy && !done) start_cyc = cyc;
        if (prev_stall && row_valid)
          chk(int'(row_addr) == prev_addr, "stall_hold", row_addr, prev_addr);
        prev_stall = row_valid && !dp_ready;
        prev_addr  = int'(row_addr);
        if (row_valid && dp_ready) begin
          if (row_q.size() == 0) begin
            chk(1'b0, "unexpected_row", {row_addr, phase}, -1);
          end else begin
            r = row_q.pop_front();
            chk(int'(row_addr) == r.addr && phase == r.ph, "row_addr_phase",
                {row_addr, phase}, {r.addr[ADDR_W-1:0], r.ph});
          end
        end
        if (row_valid) idle_run = 0;
        else idle_run++;
        if (synd_req) chk(idle_run == PIPE_LAT + 1, "drain_gap", idle_run, PIPE_LAT + 1);
        if (done) begin
          if (res_q.size() == 0) begin
            chk(1'b0, "unexpected_done", success, -1);
          end else begin
            e = res_q.pop_front();
            chk(success == e.s, "success", success, e.s);
            chk(int'(iter_cnt) == e.it, "iter_cnt", iter_cnt, e.it);
            chk(row_q.size() == 0, "rows_left_at_done", row_q.size(), 0);
            chk(!busy, "busy_at_done", busy, 0);
            if (e.lat > 0) chk(cyc - start_cyc <= e.lat, "empty_latency", cyc - start_cyc, e.lat);
          end
        end
      end
    end
  end

  // Syndrome responder: answers each synd_req after a random delay using plan[]
  initial begin : responder
    int sidx;
    int d;
    synd_valid = 1'b0;
    synd_ok    = 1'b0;
    sidx       = 0;
    forever begin
      @(negedge clk);
      if (start && !busy) sidx = 0;
      if (rst_n && synd_req) begin
        d = $urandom_range(0, 3);
        repeat (d) @(posedge clk);
        @(posedge clk); #1;
        synd_valid = 1'b1;
        synd_ok    = plan[sidx[4:0]];
        sidx++;
        @(posedge clk); #1;
        synd_valid = 1'b0;
        synd_ok    = 1'($urandom);
      end
    end
  end

  task automatic pulse_start(input int n, input int mi);
    @(posedge clk); #1;
    n_rows_in   = ADDR_W'(n);
    max_iter_in = ITER_W'(mi);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic ready_val(input int rmode, inout int stall_left);
    if (rmode == 1) return ($urandom_range(0, 3) != 0);
    if (rmode == 2 && row_valid && row_addr == ADDR_W'(2) && !phase && stall_left > 0) begin
      stall_left--;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run(input int n, input int mi, input bit [31:0] okp, input int rmode,
                     input bit restart, input bit fin_start);
    int c;
    int stall_left;
    plan = okp;
    model_push(n, mi);
    dp_ready = 1'b1;
    pulse_start(n, mi);
    c = 0;
    stall_left = 4;
    while (!done && c < 8000) begin
      n_rows_in   = ADDR_W'($urandom);
      max_iter_in = ITER_W'($urandom);
      dp_ready    = ready_val(rmode, stall_left);
      start       = restart && (c == 2);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    if (!done) tmo_events++;
    dp_ready = 1'b1;
    if (fin_start) begin
      n_rows_in = ADDR_W'(4);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : driver
    int c;
    rst_n       = 1'b0;
    start       = 1'b0;
    dp_ready    = 1'b1;
    n_rows_in   = '0;
    max_iter_in = '0;
    plan        = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run(6, 2, 32'h1, 0, 1'b0, 1'b0);
    run(5, 3, 32'h0, 0, 1'b0, 1'b0);
    run(1, 2, 32'h1, 0, 1'b0, 1'b0);
    run(0, 2, 32'h1, 0, 1'b0, 1'b0);
    run(6, 1, 32'h1, 2, 1'b0, 1'b0);
    run(8, 1, 32'h1, 0, 1'b1, 1'b1);
    run(4, 0, 32'h0, 0, 1'b0, 1'b0);

    // Abort mid odd pass with reset, then decode again from row 0.
    plan = 32'h1;
    model_push(6, 1);
    pulse_start(6, 1);
    c = 0;
    while (!(row_valid && phase) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (!(row_valid && phase)) tmo_events++;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(4, 1, 32'h1, 0, 1'b0, 1'b0);

    run(1023, 1, 32'h1, 1, 1'b0, 1'b0);
    run(1022, 1, 32'h1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run($urandom_range(0, 12), $urandom_range(0, 4), $urandom & $urandom,
          $urandom_range(0, 1), 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
